// File: rtl/io_bus_ctrl.sv
// I/O bus controller: sequences CPU memory-mapped I/O accesses,
// drives peripheral selects/strobes and stalls the CPU until done.
module io_bus_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] cpu_addr,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        cpu_err,
   output logic        sw_cs,
   output logic        kb_cs,
   output logic        tmr_cs,
   output logic        led_cs,
   output logic        io_rd,
   output logic        io_wr,
   output logic [3:0]  io_addr,
   output logic [15:0] io_wdata,
   input  logic [15:0] sw_rdata,
   input  logic [15:0] kb_rdata,
   input  logic [15:0] tmr_rdata,
   input  logic [15:0] led_rdata,
   input  logic        kb_ready,
   input  logic        tmr_ready
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE,
      S_ERR
   } state_t;

   // Select vector bit order: 0 switch, 1 keyboard, 2 timer, 3 LED
   localparam int SW  = 0;
   localparam int KB  = 1;
   localparam int TMR = 2;
   localparam int LED = 3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       cs_q, cs_d;
   logic             io_rd_q, io_rd_d;
   logic             io_wr_q, io_wr_d;
   logic [3:0]       io_addr_q, io_addr_d;
   logic [15:0]      io_wdata_q, io_wdata_d;
   logic [15:0]      rdata_q, rdata_d;
   logic             err_q, err_d;

   logic             io_req;
   logic [3:0]       dec_sel;
   logic             legal;
   logic             sel_ready;
   logic [15:0]      sel_rdata;

   // Region check and address decode of the incoming request
   always_comb begin
      io_req  = (cpu_rd | cpu_wr) & (&cpu_addr[31:10]);
      dec_sel = 4'b0000;
      case (cpu_addr[9:4])
         6'h01:   dec_sel[KB]  = 1'b1;
         6'h02:   dec_sel[TMR] = 1'b1;
         6'h06:   dec_sel[LED] = 1'b1;
         6'h07:   dec_sel[SW]  = 1'b1;
         default: dec_sel      = 4'b0000;
      endcase
      legal = (|dec_sel)
            & ~(cpu_rd & cpu_wr)
            & ~(cpu_wr & dec_sel[SW]);
   end

   // Ready and read data of the currently selected peripheral only
   always_comb begin
      sel_ready = (cs_q[SW] | cs_q[LED])
                | (cs_q[KB] & kb_ready)
                | (cs_q[TMR] & tmr_ready);
      sel_rdata = ({16{cs_q[SW]}}  & sw_rdata)
                | ({16{cs_q[KB]}}  & kb_rdata)
                | ({16{cs_q[TMR]}} & tmr_rdata)
                | ({16{cs_q[LED]}} & led_rdata);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cs_d       = 4'b0000;
      io_rd_d    = 1'b0;
      io_wr_d    = 1'b0;
      io_addr_d  = io_addr_q;
      io_wdata_d = io_wdata_q;
      rdata_d    = rdata_q;
      err_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (io_req) begin
               io_addr_d  = cpu_addr[3:0];
               io_wdata_d = cpu_wdata;
               if (legal) begin
                  state_d = S_ACCESS;
                  cs_d    = dec_sel;
                  io_rd_d = cpu_rd;
                  io_wr_d = cpu_wr;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
                  if (cpu_rd) begin
                     rdata_d = 16'h0000;
                  end
               end
            end
         end
         S_ACCESS: begin
            if (sel_ready) begin
               state_d = S_DONE;
               if (io_rd_q) begin
                  rdata_d = sel_rdata;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_ERR;
               err_d   = 1'b1;
               if (io_rd_q) begin
                  rdata_d = 16'h0000;
               end
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               cs_d    = cs_q;
               io_rd_d = io_rd_q;
               io_wr_d = io_wr_q;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         cs_q       <= 4'b0000;
         io_rd_q    <= 1'b0;
         io_wr_q    <= 1'b0;
         io_addr_q  <= 4'h0;
         io_wdata_q <= 16'h0000;
         rdata_q    <= 16'h0000;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cs_q       <= cs_d;
         io_rd_q    <= io_rd_d;
         io_wr_q    <= io_wr_d;
         io_addr_q  <= io_addr_d;
         io_wdata_q <= io_wdata_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

   // Stall is the only output combinational from the CPU request
   always_comb begin
      cpu_stall = ((state_q == S_IDLE) & io_req)
                | (state_q == S_ACCESS);
      cpu_rdata = rdata_q;
      cpu_err   = err_q;
      sw_cs     = cs_q[SW];
      kb_cs     = cs_q[KB];
      tmr_cs    = cs_q[TMR];
      led_cs    = cs_q[LED];
      io_rd     = io_rd_q;
      io_wr     = io_wr_q;
      io_addr   = io_addr_q;
      io_wdata  = io_wdata_q;
   end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Bench for io_bus_ctrl: per-cycle expected outputs are queued by
// the stimulus and compared by an independent negedge monitor.
module tb_io_bus_ctrl;

   logic        clock;
   logic        reset;
   logic [31:0] cpu_addr;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_stall;
   logic        cpu_err;
   logic        sw_cs, kb_cs, tmr_cs, led_cs;
   logic        io_rd, io_wr;
   logic [3:0]  io_addr;
   logic [15:0] io_wdata;
   logic [15:0] sw_rdata, kb_rdata, tmr_rdata, led_rdata;
   logic        kb_ready, tmr_ready;

   io_bus_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .cpu_addr  (cpu_addr),
      .cpu_rd    (cpu_rd),
      .cpu_wr    (cpu_wr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .cpu_err   (cpu_err),
      .sw_cs     (sw_cs),
      .kb_cs     (kb_cs),
      .tmr_cs    (tmr_cs),
      .led_cs    (led_cs),
      .io_rd     (io_rd),
      .io_wr     (io_wr),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .sw_rdata  (sw_rdata),
      .kb_rdata  (kb_rdata),
      .tmr_rdata (tmr_rdata),
      .led_rdata (led_rdata),
      .kb_ready  (kb_ready),
      .tmr_ready (tmr_ready)
   );

   typedef struct packed {
      logic        stall;
      logic [3:0]  cs;
      logic        rd;
      logic        wr;
      logic        err;
      logic [15:0] rdata;
      logic [3:0]  addr;
      logic [15:0] wdata;
   } obs_t;

   typedef struct {
      string nm;
      obs_t  o;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   logic [15:0] er;
   logic [3:0]  ea;
   logic [15:0] ew;

   // Clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Monitor: pop one expected snapshot per cycle and compare
   always @(negedge clock) begin
      if (q.size() > 0) begin
         exp_t e;
         obs_t a;
         e = q.pop_front();
         a = {cpu_stall, led_cs, tmr_cs, kb_cs, sw_cs,
              io_rd, io_wr, cpu_err, cpu_rdata, io_addr, io_wdata};
         n_vec++;
         if (a !== e.o) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", e.nm, a, e.o);
         end
      end
   end

   // Queue the expected outputs of this cycle, then advance one cycle
   task automatic step(input string nm, input logic s,
                       input logic [3:0] cs, input logic r,
                       input logic w, input logic e);
      exp_t x;
      x.nm = nm;
      x.o  = {s, cs, r, w, e, er, ea, ew};
      q.push_back(x);
      @(posedge clock);
      #1;
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      cpu_addr  = 32'h0;
      cpu_rd    = 1'b0;
      cpu_wr    = 1'b0;
      cpu_wdata = 16'h0;
      sw_rdata  = 16'h0;
      kb_rdata  = 16'h0;
      tmr_rdata = 16'h0;
      led_rdata = 16'h0;
      kb_ready  = 1'b0;
      tmr_ready = 1'b0;
      er = 16'h0;
      ea = 4'h0;
      ew = 16'h0;
      @(posedge clock);
      #1;
      step("reset", 0, 4'b0000, 0, 0, 0);
      reset = 1'b0;
      step("idle", 0, 4'b0000, 0, 0, 0);

      // Switch read
      cpu_addr  = 32'hFFFF_FC70;
      cpu_rd    = 1'b1;
      cpu_wdata = 16'h1234;
      sw_rdata  = 16'hA5A5;
      step("sw_rd_c0", 1, 4'b0000, 0, 0, 0);
      ea = 4'h0;
      ew = 16'h1234;
      step("sw_rd_c1", 1, 4'b0001, 1, 0, 0);
      er = 16'hA5A5;
      step("sw_rd_c2", 0, 4'b0000, 0, 0, 0);
      cpu_rd = 1'b0;

      // LED write
      cpu_addr  = 32'hFFFF_FC60;
      cpu_wr    = 1'b1;
      cpu_wdata = 16'h00FF;
      step("led_wr_c0", 1, 4'b0000, 0, 0, 0);
      ew = 16'h00FF;
      step("led_wr_c1", 1, 4'b1000, 0, 1, 0);
      step("led_wr_c2", 0, 4'b0000, 0, 0, 0);
      cpu_wr = 1'b0;
      step("idle2", 0, 4'b0000, 0, 0, 0);

      // Keyboard read, ready on 4th ACCESS cycle
      cpu_addr  = 32'hFFFF_FC1A;
      cpu_rd    = 1'b1;
      kb_rdata  = 16'h000B;
      step("kb_c0", 1, 4'b0000, 0, 0, 0);
      ea = 4'hA;
      for (int i = 1; i <= 3; i++)
         step($sformatf("kb_acc%0d", i), 1, 4'b0010, 1, 0, 0);
      kb_ready = 1'b1;
      step("kb_acc4", 1, 4'b0010, 1, 0, 0);
      er = 16'h000B;
      step("kb_done", 0, 4'b0000, 0, 0, 0);
      kb_ready = 1'b0;
      cpu_rd   = 1'b0;

      // Timer read timeout; keyboard ready must be ignored
      cpu_addr  = 32'hFFFF_FC23;
      cpu_rd    = 1'b1;
      tmr_rdata = 16'hFFFF;
      kb_ready  = 1'b1;
      step("tmr_to_c0", 1, 4'b0000, 0, 0, 0);
      ea = 4'h3;
      for (int i = 1; i <= 15; i++)
         step($sformatf("tmr_to_acc%0d", i), 1, 4'b0100, 1, 0, 0);
      er = 16'h0000;
      step("tmr_to_err", 0, 4'b0000, 0, 0, 1);
      cpu_rd   = 1'b0;
      kb_ready = 1'b0;
      step("tmr_to_idle", 0, 4'b0000, 0, 0, 0);

      // Switch read to load nonzero data
      cpu_addr = 32'hFFFF_FC77;
      cpu_rd   = 1'b1;
      sw_rdata = 16'h3C3C;
      step("sw_rd2_c0", 1, 4'b0000, 0, 0, 0);
      ea = 4'h7;
      step("sw_rd2_c1", 1, 4'b0001, 1, 0, 0);
      er = 16'h3C3C;
      step("sw_rd2_c2", 0, 4'b0000, 0, 0, 0);
      cpu_rd = 1'b0;

      // Unmapped read
      cpu_addr = 32'hFFFF_FC30;
      cpu_rd   = 1'b1;
      step("unmap_c0", 1, 4'b0000, 0, 0, 0);
      ea = 4'h0;
      er = 16'h0000;
      step("unmap_err", 0, 4'b0000, 0, 0, 1);
      cpu_rd = 1'b0;

      // Write to switch is illegal
      cpu_addr  = 32'hFFFF_FC70;
      cpu_wr    = 1'b1;
      cpu_wdata = 16'h1111;
      step("swwr_c0", 1, 4'b0000, 0, 0, 0);
      ew = 16'h1111;
      step("swwr_err", 0, 4'b0000, 0, 0, 1);
      cpu_wr = 1'b0;

      // Read and write together are illegal
      cpu_addr  = 32'hFFFF_FC65;
      cpu_rd    = 1'b1;
      cpu_wr    = 1'b1;
      cpu_wdata = 16'h2222;
      step("rdwr_c0", 1, 4'b0000, 0, 0, 0);
      ea = 4'h5;
      ew = 16'h2222;
      step("rdwr_err", 0, 4'b0000, 0, 0, 1);
      cpu_rd = 1'b0;
      cpu_wr = 1'b0;

      // Timer write, ready on first ACCESS cycle
      cpu_addr  = 32'hFFFF_FC2C;
      cpu_wr    = 1'b1;
      cpu_wdata = 16'h5A5A;
      tmr_ready = 1'b1;
      step("tmr_wr_c0", 1, 4'b0000, 0, 0, 0);
      ea = 4'hC;
      ew = 16'h5A5A;
      step("tmr_wr_c1", 1, 4'b0100, 0, 1, 0);
      step("tmr_wr_c2", 0, 4'b0000, 0, 0, 0);
      cpu_wr    = 1'b0;
      tmr_ready = 1'b0;

      // Read outside the I/O region
      cpu_addr  = 32'h0000_1000;
      cpu_rd    = 1'b1;
      cpu_wdata = 16'h9999;
      step("nonio_c0", 0, 4'b0000, 0, 0, 0);
      step("nonio_c1", 0, 4'b0000, 0, 0, 0);
      cpu_rd = 1'b0;

      // Switch read, then keyboard read interrupted by reset
      cpu_addr = 32'hFFFF_FC70;
      cpu_rd   = 1'b1;
      sw_rdata = 16'h7E7E;
      step("sw_rd3_c0", 1, 4'b0000, 0, 0, 0);
      ea = 4'h0;
      ew = 16'h9999;
      step("sw_rd3_c1", 1, 4'b0001, 1, 0, 0);
      er = 16'h7E7E;
      step("sw_rd3_c2", 0, 4'b0000, 0, 0, 0);
      cpu_addr = 32'hFFFF_FC1A;
      kb_rdata = 16'h4444;
      step("kbrst_c0", 1, 4'b0000, 0, 0, 0);
      ea = 4'hA;
      step("kbrst_acc1", 1, 4'b0010, 1, 0, 0);
      reset = 1'b1;
      step("kbrst_acc2", 1, 4'b0010, 1, 0, 0);
      reset  = 1'b0;
      cpu_rd = 1'b0;
      er = 16'h0000;
      ea = 4'h0;
      ew = 16'h0000;
      step("kbrst_after", 0, 4'b0000, 0, 0, 0);
      step("kbrst_idle", 0, 4'b0000, 0, 0, 0);

      @(posedge clock);
      #1;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL queue_drain got=%0d exp=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
